t20_cricket_scoreboard: RTL and testbench
=========================================

Name: t20_cricket_scoreboard

Overview:
- Single-clock T20 cricket game engine with a 4-digit multiplexed 7-segment display and a 16-LED status bar, for an FPGA board.
- Each `start` pulse bowls one ball. The outcome comes from a free-running LFSR.
- Runs, wickets and overs are kept for team A (innings 1) and team B (innings 2). The block decides the winner.
- Top level of the board design; it drives the display pins directly.

Parameters:
- BALLS_PER_INNINGS, 120, legal balls per innings (20 overs × 6).
- MAX_WICKETS, 10, wickets that end an innings.
- REFRESH_BITS, 18, width of the display refresh counter. Digit select = counter[REFRESH_BITS-1 -: 2].

Ports:
- clk_fpga  input  1  system clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  bowl request, level input; the rising edge is detected synchronously.
- teamSwitch  input  1  display select: 0 = team A totals, 1 = team B totals.
- dp  output  1  decimal point, active-low.
- ca  output  7  segment cathodes, active-low; ca[6]=a … ca[0]=g.
- an  output  4  digit anodes, active-low; an[3] is leftmost.
- leds  output  16  status bar.

Behaviour:
- Clocking and reset:
  - One clock: clk_fpga, rising edge.
  - Reset is asynchronous, active-high.
  - During reset: all counters = 0, LFSR = 16'hACE1, leds = 0, an = 4'b1111, ca = 7'b1111111, dp = 1.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, steps every clock.
- Ball event:
  - `start` is registered once; ball = start & ~start_q. A held level counts as one ball.
  - Outcome comes from lfsr[3:0] sampled on the same cycle:
    - 0–2 → dot
    - 3–6 → 1 run
    - 7–8 → 2 runs
    - 9 → 3 runs
    - 10–11 → 4 runs
    - 12–13 → 6 runs
    - 14–15 → wicket
  - Counters update on the clock edge where the ball is detected (latency 1 cycle from the registered edge).
- State machine: INNINGS1 → INNINGS2 → GAME_OVER.
  - INNINGS1 → INNINGS2 when A wickets reach MAX_WICKETS or A balls reach BALLS_PER_INNINGS. Ball/over counters reset to 0 for team B.
  - INNINGS2 → GAME_OVER when B wickets reach MAX_WICKETS, B balls reach BALLS_PER_INNINGS, or B runs > A runs. The check happens on the same edge as the deciding ball.
  - In GAME_OVER, start is ignored and scores are frozen.
- Winner, set on entry to GAME_OVER:
  - B runs > A runs → 2'b10.
  - B runs < A runs → 2'b01.
  - Equal → 2'b11.
  - 2'b00 while the game is in progress.
- Widths:
  - Runs: 10 bits, saturating at 999.
  - Wickets: 4 bits.
  - Balls in over: 3 bits, wraps 5→0 and increments the over count.
  - Overs: 5 bits.
- leds:
  - [15] = innings (0 = first, 1 = second).
  - [14] = game over.
  - [13:11] = balls in current over.
  - [10:6] = overs completed.
  - [5:3] = last outcome code: 0 dot, 1, 2, 3, 4 four, 5 six, 6 wicket.
  - [2:1] = winner.
  - [0] = 0.
- Display:
  - The refresh counter cycles the digits an[3]→an[0]; exactly one anode is low at a time.
  - an[3] = wickets of the selected team as a hex glyph (10 shows "A").
  - an[2:0] = runs of the selected team as BCD hundreds/tens/ones.
  - dp = 0 only while an[3] is active (wickets separator), otherwise 1.
  - Glyphs, active-low (abcdefg): 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100, A = 0001000.
- Boundary cases:
  - A ball that ends innings 1 is credited to A; the next ball goes to B.
  - A wicket on the last ball counts once.
  - Reset mid-game returns everything to INNINGS1 with zero score.
  - teamSwitch changes only the display, never the scoring.

Decomposition:
- Package t20_pkg holds:
  - Outcome code enum (DOT, ONE, TWO, THREE, FOUR, SIX, WICKET).
  - Game state enum (INNINGS1, INNINGS2, GAME_OVER).
  - Winner codes.
  - The segment glyph constants.
- One sub-module, seg7_mux: binary-to-BCD conversion, refresh counter, anode/cathode/dp drive.

Test Plan:
- Reset asserted → leds = 16'h0000, an = 4'b1111, ca = 7'b1111111, dp = 1. After release, the digits cycle and every digit shows 0; the wickets digit has dp = 0.
- Single 1-cycle start pulse → leds[13:11] = 1. leds[5:3] and team A runs match a reference LFSR model sampled on the detection cycle.
- Start held high for 5 cycles → exactly one ball counted (leds[13:11] = 1).
- Six start pulses → leds[13:11] = 0, leds[10:6] = 1.
- BALLS_PER_INNINGS = 6, then 6 pulses → leds[15] = 1 and B counters zero. teamSwitch = 1 shows team B score 000.
- BALLS_PER_INNINGS = 6 with 12 pulses (or an early chase) → leds[14] = 1 and leds[2:1] matches the compared totals. Further start pulses change nothing. Reset then returns leds = 0.

Source files
------------

// File: rtl/t20_pkg.sv
// Shared types, state/winner codes and 7-segment glyphs for the T20 scoreboard.
package t20_pkg;

    typedef enum logic [2:0] {
        DOT    = 3'd0,
        ONE    = 3'd1,
        TWO    = 3'd2,
        THREE  = 3'd3,
        FOUR   = 3'd4,
        SIX    = 3'd5,
        WICKET = 3'd6
    } outcome_e;

    localparam logic [1:0] INNINGS1  = 2'd0;
    localparam logic [1:0] INNINGS2  = 2'd1;
    localparam logic [1:0] GAME_OVER = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic outcome_e decode_ball(input logic [3:0] nib);
        if (nib <= 4'd2)       return DOT;
        else if (nib <= 4'd6)  return ONE;
        else if (nib <= 4'd8)  return TWO;
        else if (nib == 4'd9)  return THREE;
        else if (nib <= 4'd11) return FOUR;
        else if (nib <= 4'd13) return SIX;
        else                   return WICKET;
    endfunction

    function automatic logic [3:0] outcome_runs(input outcome_e oc);
        case (oc)
            ONE:     return 4'd1;
            TWO:     return 4'd2;
            THREE:   return 4'd3;
            FOUR:    return 4'd4;
            SIX:     return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            4'd10:   return SEG_A;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_mux.sv
// Four-digit multiplexed display: wickets glyph on the left, runs as BCD on the right.
module seg7_mux
    import t20_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] runs_i,
    input  logic [3:0] wickets_i,
    output logic [3:0] an_o,
    output logic [6:0] ca_o,
    output logic       dp_o
);

    logic [REFRESH_BITS-1:0] cnt_q;
    logic [1:0]              sel;
    logic [3:0]              hundreds, tens, ones;
    logic [3:0]              an_d, an_q;
    logic [6:0]              ca_d, ca_q;
    logic                    dp_d, dp_q;

    assign sel      = cnt_q[REFRESH_BITS-1 -: 2];
    // Runs saturate at 999, so three decimal digits always suffice
    assign hundreds = 4'(runs_i / 10'd100);
    assign tens     = 4'((runs_i / 10'd10) % 10'd10);
    assign ones     = 4'(runs_i % 10'd10);

    // Pick the active digit and its glyph from the refresh phase
    always_comb begin
        an_d = 4'b1111;
        ca_d = SEG_BLANK;
        dp_d = 1'b1;
        case (sel)
            2'd0: begin an_d = 4'b0111; ca_d = seg_glyph(wickets_i); dp_d = 1'b0; end
            2'd1: begin an_d = 4'b1011; ca_d = seg_glyph(hundreds); end
            2'd2: begin an_d = 4'b1101; ca_d = seg_glyph(tens); end
            default: begin an_d = 4'b1110; ca_d = seg_glyph(ones); end
        endcase
    end

    // Refresh counter and registered pin drive (blank while in reset)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            an_q  <= 4'b1111;
            ca_q  <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            an_q  <= an_d;
            ca_q  <= ca_d;
            dp_q  <= dp_d;
        end
    end

    assign an_o = an_q;
    assign ca_o = ca_q;
    assign dp_o = dp_q;

endmodule

// File: rtl/t20_cricket_scoreboard.sv
// T20 game engine: LFSR-driven balls, two innings, winner decision, LED bar and display.
module t20_cricket_scoreboard
    import t20_pkg::*;
#(
    parameter int unsigned BALLS_PER_INNINGS = 120,
    parameter int unsigned MAX_WICKETS       = 10,
    parameter int unsigned REFRESH_BITS      = 18
) (
    input  logic        clk_fpga,
    input  logic        reset,
    input  logic        start,
    input  logic        teamSwitch,
    output logic        dp,
    output logic [6:0]  ca,
    output logic [3:0]  an,
    output logic [15:0] leds
);

    localparam logic [7:0] BallsMax = 8'(BALLS_PER_INNINGS);
    localparam logic [3:0] WktsMax  = 4'(MAX_WICKETS);

    logic              start_q;
    logic [15:0]       lfsr_q;
    logic [1:0]        state_q, state_d;
    logic [1:0][9:0]   runs_q, runs_d;
    logic [1:0][3:0]   wk_q, wk_d;
    logic [1:0][2:0]   bio_q, bio_d;
    logic [1:0][4:0]   ov_q, ov_d;
    logic [1:0][7:0]   tot_q, tot_d;
    outcome_e          last_q, last_d;
    logic [1:0]        winner_q, winner_d;

    logic              ball;
    logic              bat;
    outcome_e          oc;
    logic [10:0]       run_sum;

    assign ball = start & ~start_q;
    // Team B's counters stay on show once the game is over
    assign bat  = (state_q != INNINGS1);
    assign oc   = decode_ball(lfsr_q[3:0]);

    // Score the detected ball and advance the innings/game state
    always_comb begin
        state_d  = state_q;
        runs_d   = runs_q;
        wk_d     = wk_q;
        bio_d    = bio_q;
        ov_d     = ov_q;
        tot_d    = tot_q;
        last_d   = last_q;
        winner_d = winner_q;
        run_sum  = 11'(runs_q[bat]) + 11'(outcome_runs(oc));
        if (ball && state_q != GAME_OVER) begin
            last_d      = oc;
            runs_d[bat] = (run_sum > 11'd999) ? 10'd999 : run_sum[9:0];
            if (oc == WICKET) wk_d[bat] = wk_q[bat] + 4'd1;
            tot_d[bat] = tot_q[bat] + 8'd1;
            if (bio_q[bat] == 3'd5) begin
                bio_d[bat] = 3'd0;
                ov_d[bat]  = ov_q[bat] + 5'd1;
            end else begin
                bio_d[bat] = bio_q[bat] + 3'd1;
            end
            if (state_q == INNINGS1) begin
                if (wk_d[0] == WktsMax || tot_d[0] == BallsMax) state_d = INNINGS2;
            end else if (wk_d[1] == WktsMax || tot_d[1] == BallsMax || runs_d[1] > runs_d[0]) begin
                state_d = GAME_OVER;
                if (runs_d[1] > runs_d[0])      winner_d = WIN_B;
                else if (runs_d[1] < runs_d[0]) winner_d = WIN_A;
                else                            winner_d = WIN_TIE;
            end
        end
    end

    // Game state, LFSR and start-edge register
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            lfsr_q   <= 16'hACE1;
            state_q  <= INNINGS1;
            runs_q   <= '0;
            wk_q     <= '0;
            bio_q    <= '0;
            ov_q     <= '0;
            tot_q    <= '0;
            last_q   <= DOT;
            winner_q <= WIN_NONE;
        end else begin
            start_q  <= start;
            // Fibonacci taps 16,14,13,11
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            state_q  <= state_d;
            runs_q   <= runs_d;
            wk_q     <= wk_d;
            bio_q    <= bio_d;
            ov_q     <= ov_d;
            tot_q    <= tot_d;
            last_q   <= last_d;
            winner_q <= winner_d;
        end
    end

    assign leds = {state_q != INNINGS1, state_q == GAME_OVER, bio_q[bat], ov_q[bat],
                   last_q, winner_q, 1'b0};

    seg7_mux #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_seg7_mux (
        .clk_i     (clk_fpga),
        .rst_i     (reset),
        .runs_i    (runs_q[teamSwitch]),
        .wickets_i (wk_q[teamSwitch]),
        .an_o      (an),
        .ca_o      (ca),
        .dp_o      (dp)
    );

endmodule

// File: tb/tb_t20_cricket_scoreboard.sv
// Directed bench for the T20 scoreboard with a small reference model of the game.
module tb_t20_cricket_scoreboard;

    localparam int BPI = 12;
    localparam int MWK = 10;

    logic        clk_fpga = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        teamSwitch = 1'b0;
    logic        dp;
    logic [6:0]  ca;
    logic [3:0]  an;
    logic [15:0] leds;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] glyph_tab [0:10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                     7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                     7'b0000000, 7'b0000100, 7'b0001000};
    int run_tab [0:6] = '{0, 1, 2, 3, 4, 6, 0};

    // Reference game state: 0 innings 1, 1 innings 2, 2 game over
    int m_runs [2];
    int m_wk   [2];
    int m_tot  [2];
    int m_bio  [2];
    int m_ov   [2];
    int m_state, m_last, m_win;
    logic [15:0] m_lfsr;

    t20_cricket_scoreboard #(
        .BALLS_PER_INNINGS (BPI),
        .MAX_WICKETS       (MWK),
        .REFRESH_BITS      (4)
    ) dut (
        .clk_fpga   (clk_fpga),
        .reset      (reset),
        .start      (start),
        .teamSwitch (teamSwitch),
        .dp         (dp),
        .ca         (ca),
        .an         (an),
        .leds       (leds)
    );

    always #5 clk_fpga = ~clk_fpga;

    always @(posedge clk_fpga or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            m_runs[t] = 0; m_wk[t] = 0; m_tot[t] = 0; m_bio[t] = 0; m_ov[t] = 0;
        end
        m_state = 0; m_last = 0; m_win = 0;
    endtask

    function automatic int code_of(input logic [3:0] nib);
        if (nib <= 2)       return 0;
        else if (nib <= 6)  return 1;
        else if (nib <= 8)  return 2;
        else if (nib == 9)  return 3;
        else if (nib <= 11) return 4;
        else if (nib <= 13) return 5;
        else                return 6;
    endfunction

    task automatic model_ball(input logic [3:0] nib);
        int t, c;
        if (m_state == 2) return;
        t = (m_state == 0) ? 0 : 1;
        c = code_of(nib);
        m_last = c;
        m_runs[t] = m_runs[t] + run_tab[c];
        if (m_runs[t] > 999) m_runs[t] = 999;
        if (c == 6) m_wk[t]++;
        m_tot[t]++;
        if (m_bio[t] == 5) begin m_bio[t] = 0; m_ov[t]++; end
        else m_bio[t]++;
        if (m_state == 0) begin
            if (m_wk[0] == MWK || m_tot[0] == BPI) m_state = 1;
        end else if (m_wk[1] == MWK || m_tot[1] == BPI || m_runs[1] > m_runs[0]) begin
            m_state = 2;
            if (m_runs[1] > m_runs[0])      m_win = 2;
            else if (m_runs[1] < m_runs[0]) m_win = 1;
            else                            m_win = 3;
        end
    endtask

    function automatic logic [15:0] exp_leds();
        int t;
        logic [15:0] v;
        t = (m_state == 0) ? 0 : 1;
        v = '0;
        v[15]    = (m_state != 0);
        v[14]    = (m_state == 2);
        v[13:11] = 3'(m_bio[t]);
        v[10:6]  = 5'(m_ov[t]);
        v[5:3]   = 3'(m_last);
        v[2:1]   = 2'(m_win);
        return v;
    endfunction

    // Hold start for `hold` cycles; only the rising edge counts as a ball
    task automatic bowl(input string tag, input int hold);
        logic [3:0] nib;
        start = 1'b1;
        nib = m_lfsr[3:0];
        repeat (hold) @(posedge clk_fpga);
        #1;
        start = 1'b0;
        model_ball(nib);
        @(posedge clk_fpga); #1;
        check_eq(tag, leds, exp_leds());
    endtask

    task automatic scan_display(input string tag, input int wk, input int runs);
        logic [3:0] seen;
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_fpga); #1;
            check_eq({tag, "_an_onehot"}, $countones(~an), 1);
            case (an)
                4'b0111: begin
                    check_eq({tag, "_wk"}, ca, glyph_tab[wk]);
                    check_eq({tag, "_dp_wk"}, dp, 0);
                    seen[3] = 1'b1;
                end
                4'b1011: begin
                    check_eq({tag, "_hund"}, ca, glyph_tab[runs / 100]);
                    check_eq({tag, "_dp"}, dp, 1);
                    seen[2] = 1'b1;
                end
                4'b1101: begin check_eq({tag, "_tens"}, ca, glyph_tab[(runs / 10) % 10]);
                    seen[1] = 1'b1; end
                4'b1110: begin check_eq({tag, "_ones"}, ca, glyph_tab[runs % 10]);
                    seen[0] = 1'b1; end
                default: ;
            endcase
        end
        check_eq({tag, "_all_digits"}, seen, 4'hF);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_leds"}, leds, 16'h0000);
        check_eq({tag, "_an"}, an, 4'b1111);
        check_eq({tag, "_ca"}, ca, 7'b1111111);
        check_eq({tag, "_dp"}, dp, 1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_fpga);
        #1;
        check_reset_state("rst");
        reset = 1'b0;
        scan_display("idle_a", 0, 0);

        // Single pulse, then a held level that must count once
        bowl("ball1", 1);
        check_eq("ball1_bio", leds[13:11], 1);
        scan_display("after1", m_wk[0], m_runs[0]);
        bowl("held5", 5);
        check_eq("held5_bio", leds[13:11], 2);

        for (int i = 0; i < 4; i++) bowl("over1", 1);
        check_eq("over1_bio", leds[13:11], 0);
        check_eq("over1_ov", leds[10:6], 1);

        for (int i = 0; i < 20 && m_state == 0; i++) bowl("inn1", 1);
        check_eq("inn2_flag", leds[15], 1);
        check_eq("inn2_b_zero", leds[13:6], 0);
        teamSwitch = 1'b1;
        repeat (2) @(posedge clk_fpga);
        scan_display("b_zero", 0, 0);
        teamSwitch = 1'b0;
        repeat (2) @(posedge clk_fpga);
        scan_display("a_total", m_wk[0], m_runs[0]);

        // teamSwitch toggling while B bats must not alter scoring
        for (int i = 0; i < 20 && m_state != 2; i++) begin
            teamSwitch = i[0];
            bowl("inn2", 1);
        end
        check_eq("game_over", leds[14], 1);
        check_eq("winner", leds[2:1], m_win);
        for (int i = 0; i < 3; i++) bowl("frozen", 1);
        teamSwitch = 1'b1;
        repeat (2) @(posedge clk_fpga);
        scan_display("b_final", m_wk[1], m_runs[1]);

        // Mid-game style reset returns everything to the start
        @(posedge clk_fpga); #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_state("rst2");
        @(posedge clk_fpga); #1;
        reset = 1'b0;
        @(posedge clk_fpga); #1;
        check_eq("rst2_leds_after", leds, 16'h0000);
        scan_display("rst2_b", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
